// File: rtl/rv_mem_bridge_pkg.sv
// Shared definitions for the memory-side bridge: FSM state codes, error data
// default and the per-instruction memory command record.
package rv_mem_bridge_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam int unsigned CMD_AW = 32;
  localparam int unsigned CMD_DW = 32;

  // Same layout the control FSM drives on its memory outputs.
  typedef struct packed {
    logic              we;
    logic              inv;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/rv_mem_bridge_if.sv
// Word-addressed single-port SRAM bus with a req/ack handshake; the bridge is
// the master, the SRAM (or its model) the slave.
interface rv_mem_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-3:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/rv_mem_timeout.sv
// 8-bit watchdog counter: clear, count while enabled, flag the last legal
// cycle. Saturates instead of wrapping.
module rv_mem_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/rv_mem_bridge.sv
// Memory stage: runs one core memory command against a variable-latency SRAM,
// with misalignment check, timeout watchdog and store-inverted data.
module rv_mem_bridge
  import rv_mem_bridge_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic          core_inv_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_done_o,
  output logic          core_err_o,
  output logic          core_busy_o,
  rv_mem_bridge_if.master sram
);

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-3:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          aligned;
  logic          tmo_clr;
  logic          tmo_en;
  logic          tmo_expire;

  assign aligned = (core_addr_i[1:0] == 2'b00);
  assign tmo_en  = (state_q == ST_ACCESS);

  rv_mem_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmo_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i) begin
          if (!aligned) begin
            state_d = ST_ERR;
            rdata_d = ERR_DATA;
          end else begin
            state_d = ST_ACCESS;
            we_d    = core_we_i;
            addr_d  = core_addr_i[AW-1:2];
            wdata_d = (core_we_i && core_inv_i) ? ~core_wdata_i : core_wdata_i;
            tmo_clr = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the expiry cycle still completes the access.
        if (sram.ack) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = sram.rdata;
          end
        end else if (tmo_expire) begin
          state_d = ST_ERR;
          rdata_d = ERR_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram.req     = (state_q == ST_ACCESS);
  assign sram.we      = we_q;
  assign sram.addr    = addr_q;
  assign sram.wdata   = wdata_q;

  assign core_rdata_o = rdata_q;
  assign core_done_o  = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign core_err_o   = (state_q == ST_ERR);
  assign core_busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Directed bench for rv_mem_bridge: table of memory commands with hand-computed
// results, plus reset, stray-ack and protocol sequences.
module tb_rv_mem_bridge;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] IDLE_RDATA = 32'h5555_AAAA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic          core_inv = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [DW-1:0] core_rdata;
  logic          core_done;
  logic          core_err;
  logic          core_busy;

  rv_mem_bridge_if #(.AW(AW), .DW(DW)) sram_if ();

  rv_mem_bridge #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_inv_i   (core_inv),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_rdata_o (core_rdata),
    .core_done_o  (core_done),
    .core_err_o   (core_err),
    .core_busy_o  (core_busy),
    .sram         (sram_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic        inv;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;      // ACCESS cycles without ack before the ack
    logic        ack;        // 0: never ack
    logic [31:0] resp;
    logic [29:0] exp_saddr;
    logic [31:0] exp_swdata; // compared for stores only
    int          exp_req_cyc;
    int          exp_done_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic we, logic inv, logic [31:0] addr, logic [31:0] wdata,
                              int waits, logic ack, logic [31:0] resp, logic [29:0] saddr,
                              logic [31:0] swdata, int req_cyc, int done_cyc, logic err,
                              logic [31:0] rdata);
    vec_t v;
    v.we = we; v.inv = inv; v.addr = addr; v.wdata = wdata; v.waits = waits; v.ack = ack;
    v.resp = resp; v.exp_saddr = saddr; v.exp_swdata = swdata; v.exp_req_cyc = req_cyc;
    v.exp_done_cyc = done_cyc; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    int          req_cyc;
    int          done_cyc;
    logic        stable;
    logic        busy_ok;
    logic        got_err;
    logic [31:0] got_rdata;
    core_req = 1'b1; core_we = v.we; core_inv = v.inv;
    core_addr = v.addr; core_wdata = v.wdata;
    tick();
    core_req = 1'b0;
    cyc = 1; req_cyc = 0; done_cyc = -1;
    stable = 1'b1; busy_ok = 1'b1; got_err = 1'b0; got_rdata = '0;
    while (cyc < 300 && done_cyc < 0) begin
      sram_if.ack = 1'b0;
      sram_if.rdata = IDLE_RDATA;
      if (!core_busy) busy_ok = 1'b0;
      if (sram_if.req) begin
        req_cyc++;
        if (sram_if.we !== v.we || sram_if.addr !== v.exp_saddr ||
            (v.we && sram_if.wdata !== v.exp_swdata)) stable = 1'b0;
        if (v.ack && req_cyc == v.waits + 1) begin
          sram_if.ack = 1'b1;
          sram_if.rdata = v.resp;
        end
      end
      if (core_done) begin
        done_cyc = cyc;
        got_err = core_err;
        got_rdata = core_rdata;
      end else begin
        tick();
        cyc++;
      end
    end
    sram_if.ack = 1'b0;
    check($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(v.exp_done_cyc));
    check($sformatf("v%0d err", idx), 64'(got_err), 64'(v.exp_err));
    check($sformatf("v%0d rdata", idx), 64'(got_rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d sram_req_cycles", idx), 64'(req_cyc), 64'(v.exp_req_cyc));
    check($sformatf("v%0d sram_bus_stable", idx), 64'(stable), 64'd1);
    check($sformatf("v%0d busy_during", idx), 64'(busy_ok), 64'd1);
    tick();
    check($sformatf("v%0d done_busy_after", idx), 64'({core_done, core_err, core_busy}), 64'd0);
  endtask

  // The control FSM must never strobe core_req while the bridge is busy.
  always @(negedge clk) begin
    if (rst_n && core_req && core_busy) begin
      errors++;
      $display("FAIL protocol core_req_while_busy actual=1 required=0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time actual=expired required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic no_done;
    sram_if.ack = 1'b0;
    sram_if.rdata = IDLE_RDATA;

    //             we    inv   addr          wdata         w  ack   resp          saddr          swdata        req done err   rdata
    vecs[0] = mk(1'b0, 1'b0, 32'h0000_0010, 32'h0,        0, 1'b1, 32'h1234_5678, 30'h4,        32'h0,        1, 2, 1'b0, 32'h1234_5678);
    vecs[1] = mk(1'b1, 1'b1, 32'h0000_0020, 32'h0F0F_0000, 3, 1'b1, 32'h9999_9999, 30'h8,        32'hF0F0_FFFF, 4, 5, 1'b0, 32'h1234_5678);
    vecs[2] = mk(1'b0, 1'b0, 32'h0000_0013, 32'h0,        0, 1'b1, 32'h1111_1111, 30'h0,        32'h0,        0, 1, 1'b1, 32'hDEAD_BEEF);
    vecs[3] = mk(1'b0, 1'b0, 32'h0000_0040, 32'h0,        0, 1'b0, 32'h0,        30'h10,       32'h0,        4, 5, 1'b1, 32'hDEAD_BEEF);
    vecs[4] = mk(1'b0, 1'b1, 32'h0000_0044, 32'h0000_FFFF, 3, 1'b1, 32'hA5A5_0001, 30'h11,       32'h0,        4, 5, 1'b0, 32'hA5A5_0001);
    vecs[5] = mk(1'b1, 1'b0, 32'h0000_007C, 32'hCAFE_F00D, 1, 1'b1, 32'h7777_7777, 30'h1F,       32'hCAFE_F00D, 2, 3, 1'b0, 32'hA5A5_0001);
    vecs[6] = mk(1'b1, 1'b1, 32'h0000_0022, 32'h1234_0000, 0, 1'b1, 32'h0,        30'h0,        32'h0,        0, 1, 1'b1, 32'hDEAD_BEEF);
    vecs[7] = mk(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        2, 1'b1, 32'h0000_0001, 30'h3FFF_FFFF, 32'h0,        3, 4, 1'b0, 32'h0000_0001);

    #12;
    check("reset_rdata", 64'(core_rdata), 64'd0);
    check("reset_ctrl", 64'({core_done, core_err, core_busy, sram_if.req, sram_if.we}), 64'd0);
    check("reset_sram_bus", 64'({sram_if.addr, sram_if.wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Ack while idle must be ignored.
    sram_if.ack = 1'b1;
    sram_if.rdata = 32'hBAD0_BAD0;
    tick();
    sram_if.ack = 1'b0;
    sram_if.rdata = IDLE_RDATA;
    check("stray_ack_rdata", 64'(core_rdata), 64'h0000_0001);
    check("stray_ack_ctrl", 64'({core_done, core_busy, sram_if.req}), 64'd0);

    // Asynchronous reset in the middle of an access.
    core_req = 1'b1; core_we = 1'b0; core_inv = 1'b0;
    core_addr = 32'h0000_0050; core_wdata = '0;
    tick();
    core_req = 1'b0;
    tick();
    check("rst_pre_sram_req", 64'(sram_if.req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_rdata", 64'(core_rdata), 64'd0);
    check("rst_async_ctrl", 64'({core_done, core_err, core_busy, sram_if.req, sram_if.we}), 64'd0);
    check("rst_async_sram_bus", 64'({sram_if.addr, sram_if.wdata}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_done || core_err || core_busy) no_done = 1'b0;
    end
    check("rst_no_done_pulse", 64'(no_done), 64'd1);

    run_vec(mk(1'b0, 1'b0, 32'h0000_0060, 32'h0, 0, 1'b1, 32'h0BAD_F00D, 30'h18, 32'h0,
               1, 2, 1'b0, 32'h0BAD_F00D), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_mem_bridge.md
Name: rv_mem_bridge

Overview:
- Memory-side stage directly downstream of the multicycle control FSM and datapath.
- Consumes the per-instruction memory command (memrw, inv_en, ALU-computed address, store data) and runs it against an external single-port SRAM with variable latency and a req/ack handshake.
- Returns read data for the MDR/IR path, a done pulse and an error pulse.
- Adds a timeout watchdog and a misalignment check; store-inverted (SW2) data is produced here.

Parameters:
- AW, 32, core and SRAM byte-address width.
- DW, 32, data word width.
- TIMEOUT, 16, max cycles sram_req may stay high without sram_ack; legal range 2..255.
- ERR_DATA, 32'hDEAD_BEEF, value loaded into core_rdata on any error.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- core_req, in, 1, one-cycle command strobe from the control FSM.
- core_we, in, 1, 1 = store, 0 = load/fetch; copy of memrw.
- core_inv, in, 1, store inverted data; copy of inv_en; ignored when core_we = 0.
- core_addr, in, AW, byte address.
- core_wdata, in, DW, store data (rs2).
- core_rdata, out, DW, registered read data.
- core_done, out, 1, one-cycle pulse when a command completes, successfully or not.
- core_err, out, 1, one-cycle pulse coincident with core_done on a failed command.
- core_busy, out, 1, high from the cycle after an accepted core_req until the cycle core_done is high, inclusive.
- sram_req, out, 1, held high while a transaction is outstanding.
- sram_we, out, 1, write enable; stable while sram_req is high.
- sram_addr, out, AW-2, word address = latched core_addr[AW-1:2].
- sram_wdata, out, DW, write data; stable while sram_req is high.
- sram_rdata, in, DW, valid in the sram_ack cycle for reads.
- sram_ack, in, 1, one-cycle completion acknowledge.

Behaviour:
- Reset:
  - State = IDLE; all outputs 0, except core_rdata = 0.
  - Timeout counter = 0. Latched command registers = 0.
- Reset mid-transaction abandons it; no done or err is produced.
- States:
  - IDLE: accepts core_req.
    - core_addr[1:0] != 0: go to ERR; SRAM is not touched.
    - Otherwise: latch we, addr and data, with wdata = core_inv ? ~core_wdata : core_wdata. Go to ACCESS.
  - ACCESS:
    - sram_req = 1; counter increments each cycle.
    - sram_ack = 1: go to DONE. For reads, capture sram_rdata into core_rdata in the same edge. For writes, core_rdata is unchanged.
    - sram_ack = 0 and counter == TIMEOUT-1: go to ERR and drop sram_req. An ack arriving in that same cycle wins and goes to DONE.
  - DONE: core_done = 1 for one cycle, then IDLE.
  - ERR: core_done = 1, core_err = 1 and core_rdata = ERR_DATA for one cycle, then IDLE.
- Latency (zero-wait SRAM, ack in first ACCESS cycle): core_req at cycle 0, sram_req at cycle 1, core_done at cycle 2.
- Misaligned command: core_done and core_err at cycle 1.
- core_req while not IDLE is ignored. The FSM must not issue one; the bench flags it as a protocol violation.
- sram_ack outside ACCESS is ignored.
- Counter clears on every ACCESS entry.
- Counter is 8 bits and never wraps, because TIMEOUT ≤ 255.
- core_inv only affects stores; loads never invert.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ACCESS, DONE, ERR);
  - ERR_DATA default;
  - memory command struct {we, inv, addr, wdata}, reused by the control block's memory outputs.
- Natural sub-module: rv_mem_timeout, an 8-bit clear/enable/expire counter. Everything else stays flat.

Test Plan:
- Aligned load at 0x0000_0010, sram_ack on first ACCESS cycle, sram_rdata = 0x1234_5678:
  - sram_addr = 0x4, sram_we = 0;
  - core_done at cycle 2, core_rdata = 0x1234_5678, core_err = 0.
- Store at 0x20 with wdata 0x0F0F_0000, core_inv = 1, ack after 3 wait cycles:
  - sram_wdata = 0xF0F0_FFFF, held stable for 4 cycles;
  - core_done 1 cycle after ack; core_rdata unchanged.
- Load at 0x0000_0013:
  - no sram_req;
  - core_done = core_err = 1 at cycle 1; core_rdata = 0xDEAD_BEEF.
- TIMEOUT = 4, no ack:
  - sram_req high exactly 4 cycles;
  - then core_err pulse and core_rdata = 0xDEAD_BEEF.
  - Repeat with ack on the 4th cycle: DONE, no error.
- rst_n low for 1 cycle during ACCESS:
  - all outputs 0 immediately (asynchronous);
  - no done pulse;
  - next core_req is served normally.
